decoder_scan_ctrl: RTL

//  Upstream sequencer for the 3-to-8 decoder stage. Drives the decoder's enable
//  and select inputs, stepping the select through every output in turn.

---
 rtl/decoder_scan_ctrl_if.sv | 37 +++
 rtl/decoder_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a host and decoder_scan_ctrl.
// skip_mask exists only when SCAN_MASK_EN is defined.
interface decoder_scan_ctrl_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  parameter int BLANK_W = 4
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [DWELL_W-1:0] dwell;
  logic [BLANK_W-1:0] blank;
`ifdef SCAN_MASK_EN
  logic [2**SEL_W-1:0] skip_mask;
`endif
  logic               en;
  logic [SEL_W-1:0]   a;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
`ifdef SCAN_MASK_EN
    output skip_mask,
`endif
    output start, stop, continuous, dwell, blank,
    input  en, a, busy, done, wrap
  );

  modport slave (
`ifdef SCAN_MASK_EN
    input  skip_mask,
`endif
    input  start, stop, continuous, dwell, blank,
    output en, a, busy, done, wrap
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Sweeps a 3-to-8 decoder select with a blanking gap and dwell window per code.
// Optional feature macro SCAN_MASK_EN: per-select skip mask latched at start.
//
// state | meaning
// IDLE  | no sweep; a holds last value, en=0
// BLANK | en=0 gap before the current select is driven
// DRIVE | en=1 dwell window on the current select
module decoder_scan_ctrl #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  parameter int BLANK_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  decoder_scan_ctrl_if.slave bus
);
  localparam int N = 2**SEL_W;
  localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [SEL_W-1:0]   a_q, a_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [BLANK_W-1:0] bcnt_q, bcnt_d;

  logic               next_ok;
  logic [SEL_W-1:0]   next_idx;
  logic               start_ok;
  logic [SEL_W-1:0]   start_idx;
  logic [SEL_W-1:0]   first_idx;

`ifdef SCAN_MASK_EN
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] below_a;
  logic [SEL_W:0] nxt_r, start_r, first_r;

  // Returns {found, index} of the lowest clear bit in skip.
  function automatic logic [SEL_W:0] find_lowest(input logic [N-1:0] skip);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!skip[i]) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    below_a   = ~({N{1'b1}} << ((SEL_W+1)'(a_q) + (SEL_W+1)'(1)));
    nxt_r     = find_lowest(mask_q | below_a);
    start_r   = find_lowest(bus.skip_mask);
    first_r   = find_lowest(mask_q);
    next_ok   = nxt_r[SEL_W];
    next_idx  = nxt_r[SEL_W-1:0];
    start_ok  = start_r[SEL_W];
    start_idx = start_r[SEL_W-1:0];
    first_idx = first_r[SEL_W-1:0];
  end
`else
  always_comb begin
    next_ok   = (a_q != SEL_MAX);
    next_idx  = a_q + SEL_W'(1);
    start_ok  = 1'b1;
    start_idx = '0;
    first_idx = '0;
  end
`endif

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    a_d     = a_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    dwell_d = dwell_q;
    blank_d = blank_q;
    cont_d  = cont_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
`ifdef SCAN_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          dwell_d = bus.dwell;
          blank_d = bus.blank;
          cont_d  = bus.continuous;
`ifdef SCAN_MASK_EN
          mask_d  = bus.skip_mask;
`endif
          if (start_ok) begin
            a_d     = start_idx;
            busy_d  = 1'b1;
            bcnt_d  = bus.blank;
            state_d = S_BLANK;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_BLANK: begin
        if (bus.stop) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (bcnt_q == '0) begin
          en_d    = 1'b1;
          dcnt_d  = dwell_q;
          state_d = S_DRIVE;
        end else begin
          bcnt_d  = bcnt_q - BLANK_W'(1);
        end
      end
      S_DRIVE: begin
        if (bus.stop) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (dcnt_q == '0) begin
          en_d   = 1'b0;
          bcnt_d = blank_q;
          if (next_ok) begin
            a_d     = next_idx;
            state_d = S_BLANK;
          end else begin
            wrap_d = 1'b1;
            if (cont_q) begin
              a_d     = first_idx;
              state_d = S_BLANK;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end else begin
          dcnt_d = dcnt_q - DWELL_W'(1);
        end
      end
      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      a_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
      blank_q <= '0;
      cont_q  <= 1'b0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
`ifdef SCAN_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      cont_q  <= cont_d;
      dcnt_q  <= dcnt_d;
      bcnt_q  <= bcnt_d;
`ifdef SCAN_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign bus.en   = en_q;
  assign bus.a    = a_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;
endmodule
